// File: rtl/sdr_to_ddr_dual.sv
// sdr_to_ddr_dual
// Serializes word pairs of two single-rate channels onto one DDR line,
// emulating two PDM microphones that share a data wire. Channel 0 drives
// the line while the generated pdm_clk is high, channel 1 while it is low.
// Bits are sent MSB first.
//
// Ports:
//   clk       system clock, all logic on its rising edge
//   rst_n     asynchronous active-low reset
//   en        enable serialization (words are accepted regardless)
//   s_valid   input word pair valid
//   s_ready   block can accept a word pair (pending buffer empty)
//   s_data_0  channel 0 word, driven during pdm_clk high
//   s_data_1  channel 1 word, driven during pdm_clk low
//   pdm_clk   generated bit clock, period 2*CLK_DIV clk cycles
//   ddr_data  DDR serial data
//   busy      serializer is running a word
//   underrun  one-cycle pulse when a word ends with en=1 and nothing pending

module sdr_to_ddr_dual #(
  parameter int WORD_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data_0,
  input  logic [WORD_W-1:0] s_data_1,
  output logic              pdm_clk,
  output logic              ddr_data,
  output logic              busy,
  output logic              underrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_pend_valid;
  logic [WORD_W-1:0]  r_pend_0;
  logic [WORD_W-1:0]  r_pend_1;
  logic [WORD_W-1:0]  r_sh0;
  logic [WORD_W-1:0]  r_sh1;
  logic [DIV_W-1:0]   r_div_cnt;
  logic               r_phase;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic               r_pdm_clk;
  logic               r_ddr_data;
  logic               r_underrun;

  state_t             w_state_next;
  logic               w_pend_valid_next;
  logic [WORD_W-1:0]  w_pend_0_next;
  logic [WORD_W-1:0]  w_pend_1_next;
  logic [WORD_W-1:0]  w_sh0_next;
  logic [WORD_W-1:0]  w_sh1_next;
  logic [DIV_W-1:0]   w_div_cnt_next;
  logic               w_phase_next;
  logic [BIT_W-1:0]   w_bit_cnt_next;
  logic               w_pdm_clk_next;
  logic               w_ddr_data_next;
  logic               w_underrun_next;

  logic               w_accept;
  logic               w_half_end;
  logic               w_word_end;
  logic               w_load;

  // Acceptance depends only on registered state, so s_ready never sees s_valid.
  assign w_accept   = s_valid && !r_pend_valid;
  assign w_half_end = (r_div_cnt == DIV_LAST);
  // End of the low half of the last bit: the word is finished on this edge.
  assign w_word_end = (r_state == S_RUN) && w_half_end && !r_phase && (r_bit_cnt == BIT_LAST);
  // A load either starts from idle or chains onto the previous word without a gap.
  assign w_load     = en && r_pend_valid && ((r_state == S_IDLE) || w_word_end);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pend_valid <= 1'b0;
      r_pend_0     <= '0;
      r_pend_1     <= '0;
      r_sh0        <= '0;
      r_sh1        <= '0;
      r_div_cnt    <= '0;
      r_phase      <= 1'b0;
      r_bit_cnt    <= '0;
      r_pdm_clk    <= 1'b0;
      r_ddr_data   <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pend_valid <= w_pend_valid_next;
      r_pend_0     <= w_pend_0_next;
      r_pend_1     <= w_pend_1_next;
      r_sh0        <= w_sh0_next;
      r_sh1        <= w_sh1_next;
      r_div_cnt    <= w_div_cnt_next;
      r_phase      <= w_phase_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_pdm_clk    <= w_pdm_clk_next;
      r_ddr_data   <= w_ddr_data_next;
      r_underrun   <= w_underrun_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next      = r_state;
    w_pend_valid_next = r_pend_valid;
    w_pend_0_next     = r_pend_0;
    w_pend_1_next     = r_pend_1;
    w_sh0_next        = r_sh0;
    w_sh1_next        = r_sh1;
    w_div_cnt_next    = r_div_cnt;
    w_phase_next      = r_phase;
    w_bit_cnt_next    = r_bit_cnt;
    w_pdm_clk_next    = r_pdm_clk;
    w_ddr_data_next   = r_ddr_data;
    w_underrun_next   = 1'b0;

    // Accept and load are mutually exclusive: accept needs the buffer empty,
    // load needs it full.
    if (w_accept) begin
      w_pend_0_next     = s_data_0;
      w_pend_1_next     = s_data_1;
      w_pend_valid_next = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_pdm_clk_next  = 1'b0;
        w_ddr_data_next = 1'b0;
      end
      S_RUN: begin
        if (!w_half_end) begin
          w_div_cnt_next = r_div_cnt + 1'b1;
        end else begin
          w_div_cnt_next = '0;
          if (r_phase) begin
            // High half done: present channel 1 for the low half.
            w_phase_next    = 1'b0;
            w_pdm_clk_next  = 1'b0;
            w_ddr_data_next = r_sh1[WORD_W-1];
          end else if (r_bit_cnt != BIT_LAST) begin
            w_sh0_next      = {r_sh0[WORD_W-2:0], 1'b0};
            w_sh1_next      = {r_sh1[WORD_W-2:0], 1'b0};
            w_bit_cnt_next  = r_bit_cnt + 1'b1;
            w_phase_next    = 1'b1;
            w_pdm_clk_next  = 1'b1;
            w_ddr_data_next = r_sh0[WORD_W-2];
          end else if (!w_load) begin
            w_state_next    = S_IDLE;
            w_phase_next    = 1'b0;
            w_pdm_clk_next  = 1'b0;
            w_ddr_data_next = 1'b0;
            w_underrun_next = en;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_load) begin
      w_sh0_next        = r_pend_0;
      w_sh1_next        = r_pend_1;
      w_pend_valid_next = 1'b0;
      w_bit_cnt_next    = '0;
      w_div_cnt_next    = '0;
      w_phase_next      = 1'b1;
      w_pdm_clk_next    = 1'b1;
      w_ddr_data_next   = r_pend_0[WORD_W-1];
      w_state_next      = S_RUN;
    end
  end

  // Outputs
  always_comb begin
    s_ready  = !r_pend_valid;
    busy     = (r_state == S_RUN);
    pdm_clk  = r_pdm_clk;
    ddr_data = r_ddr_data;
    underrun = r_underrun;
  end

endmodule

// File: tb/tb_sdr_to_ddr_dual.sv
// Testbench for sdr_to_ddr_dual. Lane 0 runs CLK_DIV=2, lane 1 runs CLK_DIV=1.
// Stimulus pushes the expected (high,low) bit pairs into a per-lane queue;
// a per-lane monitor decodes pdm_clk/ddr_data and pops/compares.

module tb_sdr_to_ddr_dual;

  logic       clk = 1'b0;
  logic [1:0] rst_n = 2'b00;
  logic [1:0] en = 2'b00;
  logic [1:0] s_valid = 2'b00;
  logic [1:0] s_ready;
  logic [7:0] s_data_0 [2];
  logic [7:0] s_data_1 [2];
  logic [1:0] pdm_clk;
  logic [1:0] ddr_data;
  logic [1:0] busy;
  logic [1:0] underrun;

  logic [1:0] exp_q [2][$];
  int         exp_und [2];
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      localparam int CD = (gi == 0) ? 2 : 1;

      sdr_to_ddr_dual #(.WORD_W(8), .CLK_DIV(CD)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n[gi]),
        .en       (en[gi]),
        .s_valid  (s_valid[gi]),
        .s_ready  (s_ready[gi]),
        .s_data_0 (s_data_0[gi]),
        .s_data_1 (s_data_1[gi]),
        .pdm_clk  (pdm_clk[gi]),
        .ddr_data (ddr_data[gi]),
        .busy     (busy[gi]),
        .underrun (underrun[gi])
      );

      int         und_cnt = 0;
      logic [7:0] rec0 = 8'h00;
      logic [7:0] rec1 = 8'h00;

      initial begin : mon
        logic       prev;
        logic       hi_bit;
        logic       lo_bit;
        logic       in_low;
        logic [1:0] e;
        int         hi_len;
        int         lo_len;
        prev = 0; in_low = 0; hi_len = 0; lo_len = 0; hi_bit = 0; lo_bit = 0;
        forever begin
          @(negedge clk);
          if (!rst_n[gi]) begin
            prev = 0; in_low = 0; hi_len = 0; lo_len = 0;
          end else begin
            if (underrun[gi]) und_cnt++;
            if (pdm_clk[gi] && !prev) begin
              if (in_low) chk($sformatf("lane%0d low_half_len", gi), lo_len, CD);
              hi_bit = ddr_data[gi];
              hi_len = 1;
              in_low = 0;
              rec0 = {rec0[6:0], hi_bit};
            end else if (pdm_clk[gi] && prev) begin
              hi_len++;
              chk($sformatf("lane%0d high_half_stable", gi), ddr_data[gi], hi_bit);
            end else if (!pdm_clk[gi] && prev) begin
              chk($sformatf("lane%0d high_half_len", gi), hi_len, CD);
              lo_bit = ddr_data[gi];
              lo_len = 1;
              in_low = busy[gi];
              rec1 = {rec1[6:0], lo_bit};
              if (exp_q[gi].size() == 0) begin
                n_total++;
                $display("FAIL lane%0d unexpected_bit: got pair %0d%0d expected none", gi, hi_bit, lo_bit);
              end else begin
                e = exp_q[gi].pop_front();
                chk($sformatf("lane%0d bit_pair", gi), {hi_bit, lo_bit}, e);
              end
            end else begin
              if (!busy[gi]) in_low = 0;
              else lo_len++;
            end
            prev = pdm_clk[gi];
          end
        end
      end
    end
  endgenerate

  // Push expectations, then hold s_valid until the handshake edge.
  // Returns #1 after the accepting edge.
  task automatic send(input int lane, input logic [7:0] d0, input logic [7:0] d1);
    int n;
    for (int i = 7; i >= 0; i--) exp_q[lane].push_back({d0[i], d1[i]});
    @(negedge clk);
    s_data_0[lane] = d0;
    s_data_1[lane] = d1;
    s_valid[lane]  = 1'b1;
    n = 0;
    while (!s_ready[lane] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_wait", int'(s_ready[lane]), 1);
    @(posedge clk);
    #1 s_valid[lane] = 1'b0;
    $display("lane %0d sent %02h/%02h", lane, d0, d1);
  endtask

  task automatic wait_idle(input int lane);
    int n;
    n = 0;
    while (busy[lane] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", int'(busy[lane]), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    s_data_0[0] = 8'h11; s_data_1[0] = 8'h22;
    s_data_0[1] = 8'h00; s_data_1[1] = 8'h00;
    exp_und[0] = 0; exp_und[1] = 0;

    // 1: reset with s_valid high
    s_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pdm_clk",  pdm_clk[0],  0);
    chk("rst_ddr_data", ddr_data[0], 0);
    chk("rst_busy",     busy[0],     0);
    chk("rst_underrun", underrun[0], 0);
    chk("rst_s_ready",  s_ready[0],  1);
    s_valid[0] = 1'b0;
    rst_n = 2'b11;
    repeat (10) @(negedge clk);
    chk("post_rst_s_ready", s_ready[0], 1);
    chk("post_rst_pdm_clk", pdm_clk[0], 0);
    chk("post_rst_busy",    busy[0],    0);
    $display("test1 reset done");

    // 2: single word, latency and underrun
    en[0] = 1'b1;
    send(0, 8'hA5, 8'h3C);
    chk("t2_pdm_before_load", pdm_clk[0], 0);
    @(posedge clk); #1;
    chk("t2_first_high",  pdm_clk[0],  1);
    chk("t2_first_bit",   ddr_data[0], 1);
    chk("t2_busy",        busy[0],     1);
    exp_und[0]++;
    wait_idle(0);
    @(negedge clk);
    chk("t2_end_pdm_clk", pdm_clk[0], 0);
    chk("t2_underrun_count", g_lane[0].und_cnt, exp_und[0]);
    $display("test2 single word done");

    // 3: back-to-back words
    send(0, 8'hFF, 8'h00);
    chk("t3_ready_low_after_accept", s_ready[0], 0);
    @(posedge clk); #1;
    chk("t3_ready_high_after_load", s_ready[0], 1);
    send(0, 8'h00, 8'hFF);
    chk("t3_no_underrun_midstream", g_lane[0].und_cnt, exp_und[0]);
    exp_und[0]++;
    wait_idle(0);
    @(negedge clk);
    chk("t3_underrun_count", g_lane[0].und_cnt, exp_und[0]);
    $display("test3 back-to-back done");

    // 4: en dropped mid-word with a second word pending
    send(0, 8'h5A, 8'hC3);
    @(posedge clk); #1;
    send(0, 8'h96, 8'h0F);
    repeat (10) @(posedge clk);
    #1 en[0] = 1'b0;
    wait_idle(0);
    repeat (6) @(negedge clk);
    chk("t4_pdm_parked",   pdm_clk[0], 0);
    chk("t4_pend_retained", s_ready[0], 0);
    chk("t4_no_underrun",  g_lane[0].und_cnt, exp_und[0]);
    chk("t4_half_consumed", exp_q[0].size(), 8);
    en[0] = 1'b1;
    @(posedge clk); #1;
    chk("t4_restart_high", pdm_clk[0],  1);
    chk("t4_restart_bit",  ddr_data[0], 1);
    exp_und[0]++;
    wait_idle(0);
    @(negedge clk);
    chk("t4_underrun_count", g_lane[0].und_cnt, exp_und[0]);
    $display("test4 en drop done");

    // 5: reset mid-word at bit 5 high half
    send(0, 8'hC7, 8'hE1);
    repeat (21) @(posedge clk);
    #1;
    chk("t5_bit5_high", pdm_clk[0], 1);
    #1 rst_n[0] = 1'b0;
    #1;
    chk("t5_rst_pdm_clk",  pdm_clk[0],  0);
    chk("t5_rst_ddr_data", ddr_data[0], 0);
    chk("t5_rst_busy",     busy[0],     0);
    chk("t5_rst_s_ready",  s_ready[0],  1);
    chk("t5_bits_popped",  exp_q[0].size(), 3);
    exp_q[0].delete();
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("t5_no_resume_pdm",  pdm_clk[0], 0);
    chk("t5_no_resume_busy", busy[0],    0);
    $display("test5 mid-word reset done");

    // 6: CLK_DIV=1 lane, loopback recovery
    en[1] = 1'b1;
    send(1, 8'h80, 8'h01);
    @(posedge clk); #1;
    chk("t6_first_high", pdm_clk[1], 1);
    @(posedge clk); #1;
    chk("t6_first_low",  pdm_clk[1], 0);
    exp_und[1]++;
    wait_idle(1);
    @(negedge clk);
    chk("t6_recovered_ch0", g_lane[1].rec0, 8'h80);
    chk("t6_recovered_ch1", g_lane[1].rec1, 8'h01);
    chk("t6_underrun_count", g_lane[1].und_cnt, exp_und[1]);
    $display("test6 clk_div=1 done");

    repeat (5) @(negedge clk);
    chk("final_q0_empty", exp_q[0].size(), 0);
    chk("final_q1_empty", exp_q[1].size(), 0);
    chk("final_und0", g_lane[0].und_cnt, exp_und[0]);
    chk("final_und1", g_lane[1].und_cnt, exp_und[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdr_to_ddr_dual.md
Name: sdr_to_ddr_dual

Overview:
Transmit-side counterpart of the dual-mic DDR-to-SDR capture path. It takes parallel words of two single-rate channels over a valid/ready handshake and serializes them MSB-first onto one DDR line: channel 0 drives the line while the generated pdm_clk is high, channel 1 while it is low. It generates pdm_clk from the system clock. It is used to emulate two PDM mics sharing a data line and to loop back into the capture path.

Parameters:
WORD_W, 8, bits per channel word (>=2)
CLK_DIV, 2, system clk cycles per pdm_clk half-period (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  enable serialization
s_valid  in  1  input word pair valid
s_ready  out  1  block can accept a word pair
s_data_0  in  WORD_W  channel 0 word (driven during pdm_clk high)
s_data_1  in  WORD_W  channel 1 word (driven during pdm_clk low)
pdm_clk  out  1  generated bit clock, period 2*CLK_DIV clk
ddr_data  out  1  DDR serial data
busy  out  1  state RUN
underrun  out  1  one-cycle pulse when a word ends with en=1 and no pending word

Behaviour:
- Reset (async assert, sync deassert assumed upstream): pdm_clk=0, ddr_data=0, busy=0, underrun=0, pending buffer empty, shift regs=0, state IDLE. s_ready=1 during and after reset.
- Storage: one pending register pair (pend_valid) plus shift registers sh0/sh1. s_ready = !pend_valid (no combinational path from s_valid). A transfer occurs on an edge where s_valid && s_ready. It loads pend and sets pend_valid. A transfer is accepted regardless of en.
- Counters: div_cnt 0..CLK_DIV-1 (half-period), phase bit (1=high half), bit_cnt 0..WORD_W-1.
- IDLE: pdm_clk=0, ddr_data=0. If en && pend_valid: load sh0/sh1 from pend, clear pend_valid, bit_cnt=0, div_cnt=0. On that same edge register pdm_clk=1, ddr_data=pend_0[WORD_W-1], busy=1, and go to RUN. Latency: first pdm_clk high is registered on the first edge after the accepting edge.
- RUN: each half-period lasts exactly CLK_DIV clk cycles. At the end of a high half: pdm_clk=0, ddr_data=sh1 current MSB. At the end of a low half:
  - if bit_cnt<WORD_W-1: shift both regs left, bit_cnt++, pdm_clk=1, ddr_data=next sh0 MSB.
  - on the last bit, if en && pend_valid: reload from pend with no gap (pdm_clk continuous), clear pend_valid.
  - on the last bit, if en && !pend_valid: underrun=1 for one cycle, go to IDLE.
  - on the last bit, if !en: go to IDLE, no underrun.
- en deasserted mid-word: the current word completes, then IDLE. The pending word is retained for the next en.
- Outputs pdm_clk and ddr_data are registered (glitch-free). The duty cycle is exactly 50%.
- Sustained throughput: one word pair per 2*CLK_DIV*WORD_W clk. s_ready reasserts the cycle after a load.
- rst_n asserted mid-operation: immediate return to reset values. Pending and in-flight data are discarded.
- Width rule: shifts are left, zero-fill. Counters are sized $clog2 of their range with minimum 1 bit.

Test Plan:
1. Reset: rst_n=0 with s_valid=1 -> pdm_clk=0, ddr_data=0, busy=0, underrun=0, s_ready=1, no transfer; after release, outputs remain idle until en=1.
2. Single word (WORD_W=8, CLK_DIV=2, en=1): s_data_0=0xA5, s_data_1=0x3C -> the (high,low) pairs are (1,0),(0,0),(1,1),(0,1),(0,1),(1,1),(0,0),(1,0). Each half lasts 2 clk and pdm_clk toggles every 2 clk for 32 clk. Then underrun pulses 1 cycle, busy=0, pdm_clk=0.
3. Back-to-back: 0xFF/0x00 then 0x00/0xFF offered continuously -> no pdm_clk gap between words and ddr_data alternates 1,0 for 8 bits then 0,1. s_ready drops after the first accept and rises the cycle after the load. No underrun until the stream ends.
4. en deasserted at bit 3 of a word while a second word is pending -> the current word finishes all 8 bits and no underrun occurs. pdm_clk stays 0 and pend is retained. When en=1 is reasserted, the second word starts one edge later.
5. rst_n pulsed low mid-word (bit 5, high half) -> pdm_clk and ddr_data go 0 immediately, busy=0, s_ready=1; the old word never resumes.
6. CLK_DIV=1, words 0x80/0x01 -> pdm_clk toggles every clk. ddr_data pairs are (1,0) for bit 0, (0,0) for bits 1-6 and (0,1) for bit 7. Loopback into the capture block recovers 0x80 and 0x01.
